// File: rtl/pipe_stage_sched.sv
// -----------------------------------------------------------------------------
// pipe_stage_sched
//
// Valid/ready scheduler for the iterative series-evaluation pipeline. It tracks
// which of the STAGES datapath stages hold a live item. It drives the per-stage
// hold/advance select of the stage mux groups. It can drop items whose stage
// reports arithmetic overflow. It keeps occupancy and overflow statistics.
//
// Parameters
//   STAGES    number of pipeline stages (2..15)
//   DROP_OVF  1 = kill an item when its stage reports overflow,
//             0 = let an overflowed item propagate to the output
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset (highest priority)
//   flush        synchronous clear of all stage valid bits; ovf_cnt retained
//   in_valid     upstream presents a new x
//   in_ready     stage 0 can accept (combinational)
//   stage_ovf    per-stage overflow flag from the datapath
//   stage_sel    per-stage mux select, 1 = advance (load upstream), 0 = hold
//   stage_valid  registered occupancy bit per stage
//   out_valid    last stage holds a live result
//   out_ovf      stage_ovf[STAGES-1] qualified by out_valid
//   out_ready    consumer accepts a result
//   occ          registered count of occupied stages
//   ovf_cnt      saturating count of overflowed items
//   idle         occ == 0
// -----------------------------------------------------------------------------
module pipe_stage_sched #(
  parameter int STAGES   = 4,
  parameter bit DROP_OVF = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [STAGES-1:0] stage_ovf,
  output logic [STAGES-1:0] stage_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic              out_valid,
  output logic              out_ovf,
  input  logic              out_ready,
  output logic [3:0]        occ,
  output logic [7:0]        ovf_cnt,
  output logic              idle
);

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] kill;
  logic [STAGES-1:0] ev;
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] v_nxt;
  logic [3:0]        ovf_inc;
  logic [8:0]        ovf_sum;
  logic [7:0]        ovf_cnt_nxt;

  // Number of set bits in a stage vector; STAGES <= 15 always fits in 4 bits.
  function automatic logic [3:0] popcount(input logic [STAGES-1:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    kill        = '0;
    ev          = '0;
    rdy         = '0;
    v_nxt       = '0;
    ovf_inc     = '0;
    ovf_sum     = '0;
    ovf_cnt_nxt = ovf_cnt;

    // A killed item no longer counts as occupying its stage. That is what
    // lets the slot be overwritten in the same edge instead of leaving a
    // bubble that stalls upstream.
    kill = v & stage_ovf & {STAGES{DROP_OVF}};
    ev   = v & ~kill;

    // Ready ripples from the consumer back to stage 0. A stage can load when
    // it is empty (or killed) or when its own item moves on.
    rdy[STAGES-1] = ~ev[STAGES-1] | out_ready;
    for (int i = STAGES - 2; i >= 0; i--) begin
      rdy[i] = ~ev[i] | rdy[i+1];
    end

    // Stage 0 loads the upstream request; every later stage loads the
    // effective valid of its predecessor, so killed items become bubbles.
    v_nxt[0] = stage_sel[0] ? in_valid : v[0];
    for (int i = 1; i < STAGES; i++) begin
      v_nxt[i] = stage_sel[i] ? ev[i-1] : v[i];
    end

    if (DROP_OVF) begin
      ovf_inc = popcount(kill);
    end else begin
      ovf_inc = {3'b000, out_valid & out_ready & stage_ovf[STAGES-1]};
    end

    ovf_sum     = {1'b0, ovf_cnt} + {5'b00000, ovf_inc};
    ovf_cnt_nxt = ovf_sum[8] ? 8'hFF : ovf_sum[7:0];
  end

  // flush freezes every stage so nothing is accepted or advanced in that cycle.
  assign stage_sel   = rdy & {STAGES{~flush}};
  assign in_ready    = rdy[0] & ~flush;
  assign stage_valid = v;
  assign out_valid   = ev[STAGES-1];
  assign out_ovf     = out_valid & stage_ovf[STAGES-1];
  assign idle        = (occ == 4'd0);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    if (rst) begin
      v       <= '0;
      occ     <= '0;
      ovf_cnt <= '0;
    end else if (flush) begin
      v       <= '0;
      occ     <= '0;
    end else begin
      v       <= v_nxt;
      occ     <= popcount(v_nxt);
      ovf_cnt <= ovf_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_stage_sched.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_sched
//
// Self-checking bench for pipe_stage_sched. It runs two instances, with
// STAGES=4, side by side on the same stimulus:
//   u_drop  DROP_OVF=1
//   u_pass  DROP_OVF=0
// When a test issues items, the expected result beats go into one queue per
// instance: the cycle number of the beat and its out_ovf value. A monitor per
// instance pops and compares on every beat (out_valid & out_ready). The main
// process checks state outputs directly. Inputs change #1 after the rising
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage_sched;

  localparam int STAGES = 4;

  typedef struct {
    int cyc;
    int ovf;
  } beat_t;

  logic              clk;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic [STAGES-1:0] stage_ovf;
  logic              out_ready;

  logic              d_in_ready,  p_in_ready;
  logic [STAGES-1:0] d_stage_sel, p_stage_sel;
  logic [STAGES-1:0] d_stage_valid, p_stage_valid;
  logic              d_out_valid, p_out_valid;
  logic              d_out_ovf,   p_out_ovf;
  logic [3:0]        d_occ,       p_occ;
  logic [7:0]        d_ovf_cnt,   p_ovf_cnt;
  logic              d_idle,      p_idle;

  int    vectors = 0;
  int    errors  = 0;
  int    cyc     = 0;
  int    t0;
  beat_t q_drop[$];
  beat_t q_pass[$];

  pipe_stage_sched #(.STAGES(STAGES), .DROP_OVF(1'b1)) u_drop (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(d_in_ready), .stage_ovf(stage_ovf), .stage_sel(d_stage_sel),
    .stage_valid(d_stage_valid), .out_valid(d_out_valid), .out_ovf(d_out_ovf),
    .out_ready(out_ready), .occ(d_occ), .ovf_cnt(d_ovf_cnt), .idle(d_idle)
  );

  pipe_stage_sched #(.STAGES(STAGES), .DROP_OVF(1'b0)) u_pass (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ready(p_in_ready), .stage_ovf(stage_ovf), .stage_sel(p_stage_sel),
    .stage_valid(p_stage_valid), .out_valid(p_out_valid), .out_ovf(p_out_ovf),
    .out_ready(out_ready), .occ(p_occ), .ovf_cnt(p_ovf_cnt), .idle(p_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_both(input int c, input int ovf_d, input int ovf_p);
    beat_t b;
    b.cyc = c;
    b.ovf = ovf_d;
    q_drop.push_back(b);
    b.ovf = ovf_p;
    q_pass.push_back(b);
  endtask

  // Scoreboard monitors: one per instance.
  initial forever begin
    beat_t e;
    @(negedge clk);
    if (d_out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q_drop.size() == 0) begin
        vectors = vectors + 1;
        errors  = errors + 1;
        $display("FAIL drop_beat unexpected at cycle %0d", cyc);
      end else begin
        e = q_drop.pop_front();
        check("drop_beat_cycle", cyc, e.cyc);
        check("drop_beat_ovf", int'(d_out_ovf), e.ovf);
      end
    end
  end

  initial forever begin
    beat_t e;
    @(negedge clk);
    if (p_out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q_pass.size() == 0) begin
        vectors = vectors + 1;
        errors  = errors + 1;
        $display("FAIL pass_beat unexpected at cycle %0d", cyc);
      end else begin
        e = q_pass.pop_front();
        check("pass_beat_cycle", cyc, e.cyc);
        check("pass_beat_ovf", int'(p_out_ovf), e.ovf);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    stage_ovf = '0;
    out_ready = 1'b1;

    // ---- Reset: two cycles, then release
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_stage_valid", int'(d_stage_valid), 0);
    check("rst_out_valid",   int'(d_out_valid), 0);
    check("rst_out_ovf",     int'(p_out_ovf), 0);
    check("rst_occ",         int'(d_occ), 0);
    check("rst_ovf_cnt",     int'(d_ovf_cnt), 0);
    check("rst_in_ready",    int'(d_in_ready), 1);
    check("rst_idle",        int'(p_idle), 1);
    tick();

    // ---- Streaming: 6 back-to-back items, latency 4, occ saturates at 4
    t0 = cyc;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1;
      push_both(cyc + STAGES, 0, 0);
      @(negedge clk);
      check("stream_occ", int'(d_occ), (k < 4) ? k : 4);
      check("stream_in_ready", int'(d_in_ready), 1);
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    check("stream_idle", int'(d_idle), 1);
    tick();

    // ---- Backpressure: fill 4, stall 5 cycles with an item offered, release
    t0 = cyc;
    for (int k = 0; k < 4; k++) push_both(t0 + 9 + k, 0, 0);
    push_both(t0 + 13, 0, 0);
    for (int k = 0; k < 15; k++) begin
      in_valid  = (k <= 9);
      out_ready = !(k >= 4 && k <= 8);
      @(negedge clk);
      if (k >= 4 && k <= 8) begin
        check("bp_stage_sel", int'(d_stage_sel), 0);
        check("bp_in_ready",  int'(d_in_ready), 0);
        check("bp_occ",       int'(d_occ), 4);
      end
      if (k == 9) begin
        check("bp_release_sel",   int'(p_stage_sel), 15);
        check("bp_release_ready", int'(p_in_ready), 1);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle", int'(d_idle), 1);
    tick();

    // ---- Overflow on item B (2nd of 4): flagged while B is in stages 1..3
    t0 = cyc;
    push_both(t0 + 4, 0, 0);
    push_both(t0 + 5, 0, 1);  // B: the drop instance must not emit it
    void'(q_drop.pop_back());
    push_both(t0 + 6, 0, 0);
    push_both(t0 + 7, 0, 0);
    for (int k = 0; k < 10; k++) begin
      in_valid  = (k < 4);
      stage_ovf = (k == 3) ? 4'b0010 : (k == 4) ? 4'b0100 :
                  (k == 5) ? 4'b1000 : 4'b0000;
      @(negedge clk);
      if (k == 4) begin
        check("ovf_drop_cnt_after_kill", int'(d_ovf_cnt), 1);
        check("ovf_drop_bubble",         int'(d_stage_valid), 4'b1011);
        check("ovf_pass_cnt_before",     int'(p_ovf_cnt), 0);
      end
      if (k == 5) check("ovf_pass_cnt_at_exit", int'(p_ovf_cnt), 0);
      if (k == 6) begin
        check("ovf_pass_cnt_after_fire", int'(p_ovf_cnt), 1);
        check("ovf_drop_cnt_stable",     int'(d_ovf_cnt), 1);
      end
      tick();
    end
    in_valid  = 1'b0;
    stage_ovf = '0;

    // ---- Saturation: stage 0 killed every cycle, 300 cycles
    out_ready = 1'b0;
    in_valid  = 1'b1;
    stage_ovf = 4'b0001;
    repeat (300) tick();
    @(negedge clk);
    check("sat_drop_cnt",      int'(d_ovf_cnt), 255);
    check("sat_drop_in_ready", int'(d_in_ready), 1);
    check("sat_drop_occ",      int'(d_occ), 1);
    check("sat_pass_cnt",      int'(p_ovf_cnt), 1);
    check("sat_pass_occ",      int'(p_occ), 4);
    tick();
    in_valid  = 1'b0;
    stage_ovf = '0;
    flush     = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("sat_flush_occ", int'(p_occ), 0);
    tick();

    // ---- Flush with 3 items in flight and a simultaneous in_valid
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      tick();
    end
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready",  int'(d_in_ready), 0);
    check("flush_stage_sel", int'(d_stage_sel), 0);
    check("flush_occ_before", int'(d_occ), 3);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("flush_stage_valid", int'(d_stage_valid), 0);
    check("flush_occ",         int'(p_occ), 0);
    check("flush_idle",        int'(d_idle), 1);
    check("flush_drop_cnt",    int'(d_ovf_cnt), 255);
    check("flush_pass_cnt",    int'(p_ovf_cnt), 1);
    repeat (5) tick();

    // ---- rst and flush together: rst wins, counters cleared
    rst   = 1'b1;
    flush = 1'b1;
    tick();
    rst   = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    check("rstflush_drop_cnt", int'(d_ovf_cnt), 0);
    check("rstflush_pass_cnt", int'(p_ovf_cnt), 0);
    check("rstflush_idle",     int'(d_idle), 1);
    tick();

    // ---- Kill on the last stage while out_ready = 1: no beat from u_drop
    t0 = cyc;
    in_valid = 1'b1;
    begin
      beat_t b;
      b.cyc = t0 + 4;
      b.ovf = 1;
      q_pass.push_back(b);
    end
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    stage_ovf = 4'b1000;
    @(negedge clk);
    check("lastkill_drop_out_valid", int'(d_out_valid), 0);
    check("lastkill_pass_out_valid", int'(p_out_valid), 1);
    tick();
    stage_ovf = '0;
    @(negedge clk);
    check("lastkill_drop_cnt",  int'(d_ovf_cnt), 1);
    check("lastkill_pass_cnt",  int'(p_ovf_cnt), 1);
    check("lastkill_drop_idle", int'(d_idle), 1);
    repeat (3) tick();

    check("drop_queue_left", q_drop.size(), 0);
    check("pass_queue_left", q_pass.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
